// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: stall encodings,
// the per-edge operation decode and the statistics counter width.
package pipe_pkg;

  typedef enum logic {
    NO_STOP = 1'b0,
    STOP    = 1'b1
  } stall_e;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_BUBBLE,
    OP_FLUSH
  } stage_op_e;

  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] ZERO_WORD = '0;

  // A stopped stage emits a bubble only when the stage after it can move.
  function automatic stage_op_e decode_op(input logic flush,
                                          input logic stop_here,
                                          input logic stop_next);
    stage_op_e op;
    if (flush)
      op = OP_FLUSH;
    else if (stop_here == STOP && stop_next == NO_STOP)
      op = OP_BUBBLE;
    else if (stop_here == NO_STOP)
      op = OP_LOAD;
    else
      op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with optional parallel load; the increment applies
// to the loaded value when both load and inc are asserted on the same edge.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] base;

  always_comb begin
    base = load ? load_val : count_q;
    count_d = base;
    if (clear)
      count_d = '0;
    else if (inc && base != {WIDTH{1'b1}})
      count_d = base + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush / bubble-insert / load / hold priority.
// Define PIPE_STAGE_STAT_EN to build the bubble and flush statistics counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DW      = 160,
  parameter int LANES   = 1,
  parameter int STALL_W = 6,
  parameter int STAGE   = 2,
  parameter int CNT_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic [LANES-1:0]      in_valid,
  input  logic [LANES*DW-1:0]   in_data,
  input  logic [LANES-1:0]      in_bubble,
  input  logic                  slot_flag_i,
  input  logic [CNT_W-1:0]      hold_cnt_i,
  output logic [LANES-1:0]      out_valid,
  output logic [LANES*DW-1:0]   out_data,
  output logic [LANES-1:0]      out_bubble,
  output logic                  slot_flag_o,
  output logic [CNT_W-1:0]      hold_cnt_o,
  output logic [STAT_W-1:0]     stat_bubble_cnt,
  output logic [STAT_W-1:0]     stat_flush_cnt
);

  stage_op_e             op;
  logic [LANES-1:0]      out_valid_q, out_valid_d;
  logic [LANES-1:0]      out_bubble_q, out_bubble_d;
  logic [LANES*DW-1:0]   out_data_q, out_data_d;
  logic                  slot_flag_q, slot_flag_d;
  logic                  is_bubble, is_flush;
  logic                  unused_stall;

  // Only two stall bits matter here; the rest belong to other stages.
  assign unused_stall = ^stall;

  assign op        = decode_op(flush, stall[STAGE], stall[STAGE+1]);
  assign is_bubble = (op == OP_BUBBLE);
  assign is_flush  = (op == OP_FLUSH);

  always_comb begin
    out_valid_d  = out_valid_q;
    out_bubble_d = out_bubble_q;
    out_data_d   = out_data_q;
    slot_flag_d  = slot_flag_q;
    unique case (op)
      OP_FLUSH: begin
        out_valid_d  = '0;
        out_data_d   = '0;
        out_bubble_d = '1;
        slot_flag_d  = 1'b0;
      end
      OP_BUBBLE: begin
        out_valid_d  = '0;
        out_data_d   = '0;
        out_bubble_d = '1;
      end
      OP_LOAD: begin
        out_valid_d  = in_valid;
        out_bubble_d = in_bubble;
        slot_flag_d  = slot_flag_i;
        for (int k = 0; k < LANES; k++)
          out_data_d[k*DW +: DW] = in_valid[k] ? in_data[k*DW +: DW] : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= '0;
      out_bubble_q <= '0;
      out_data_q   <= '0;
      slot_flag_q  <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_bubble_q <= out_bubble_d;
      out_data_q   <= out_data_d;
      slot_flag_q  <= slot_flag_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_bubble  = out_bubble_q;
  assign out_data    = out_data_q;
  assign slot_flag_o = slot_flag_q;

  // Bubble edges report one more than upstream; flush and load restart at zero.
  sat_counter #(.WIDTH(CNT_W)) u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (is_flush || op == OP_LOAD),
    .load     (is_bubble),
    .load_val (hold_cnt_i),
    .inc      (is_bubble),
    .count    (hold_cnt_o)
  );

`ifdef PIPE_STAGE_STAT_EN
  sat_counter #(.WIDTH(STAT_W)) u_stat_bubble (
    .clk      (clk),
    .rst      (rst),
    .clear    (1'b0),
    .load     (1'b0),
    .load_val (ZERO_WORD),
    .inc      (is_bubble),
    .count    (stat_bubble_cnt)
  );

  sat_counter #(.WIDTH(STAT_W)) u_stat_flush (
    .clk      (clk),
    .rst      (rst),
    .clear    (1'b0),
    .load     (1'b0),
    .load_val (ZERO_WORD),
    .inc      (is_flush),
    .count    (stat_flush_cnt)
  );
`else
  assign stat_bubble_cnt = ZERO_WORD;
  assign stat_flush_cnt  = ZERO_WORD;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scoreboard bench for pipe_stage_reg with two 8-bit lanes at stage 2;
// statistics expectations follow whether PIPE_STAGE_STAT_EN is defined.
module tb_pipe_stage_reg;

  localparam int DW      = 8;
  localparam int LANES   = 2;
  localparam int STALL_W = 6;
  localparam int STAGE   = 2;
  localparam int CNT_W   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [STALL_W-1:0]  stall;
  logic                flush;
  logic [LANES-1:0]    in_valid;
  logic [LANES*DW-1:0] in_data;
  logic [LANES-1:0]    in_bubble;
  logic                slot_flag_i;
  logic [CNT_W-1:0]    hold_cnt_i;
  logic [LANES-1:0]    out_valid;
  logic [LANES*DW-1:0] out_data;
  logic [LANES-1:0]    out_bubble;
  logic                slot_flag_o;
  logic [CNT_W-1:0]    hold_cnt_o;
  logic [15:0]         stat_bubble_cnt;
  logic [15:0]         stat_flush_cnt;

  typedef struct packed {
    logic [1:0]  valid;
    logic [15:0] data;
    logic [1:0]  bubble;
    logic        slot;
    logic [1:0]  hold;
    logic [15:0] sb;
    logic [15:0] sf;
  } exp_t;

  exp_t exp_q[$];
  exp_t model;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DW(DW), .LANES(LANES), .STALL_W(STALL_W), .STAGE(STAGE), .CNT_W(CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_bubble       (in_bubble),
    .slot_flag_i     (slot_flag_i),
    .hold_cnt_i      (hold_cnt_i),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_bubble      (out_bubble),
    .slot_flag_o     (slot_flag_o),
    .hold_cnt_o      (hold_cnt_o),
    .stat_bubble_cnt (stat_bubble_cnt),
    .stat_flush_cnt  (stat_flush_cnt)
  );

  task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string step);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard empty", step);
    end else begin
      e = exp_q.pop_front();
      compare({step, ".valid"},  {14'd0, out_valid},  {14'd0, e.valid});
      compare({step, ".data"},   out_data,            e.data);
      compare({step, ".bubble"}, {14'd0, out_bubble}, {14'd0, e.bubble});
      compare({step, ".slot"},   {15'd0, slot_flag_o}, {15'd0, e.slot});
      compare({step, ".hold"},   {14'd0, hold_cnt_o}, {14'd0, e.hold});
      compare({step, ".sbub"},   stat_bubble_cnt,     e.sb);
      compare({step, ".sflush"}, stat_flush_cnt,      e.sf);
    end
  endtask

  // Drive one edge worth of inputs, predict its result, then check after the edge.
  task automatic apply_stimulus(input string step, input logic r, input logic [5:0] st,
                                input logic fl, input logic [1:0] v, input logic [15:0] d,
                                input logic [1:0] b, input logic sl, input logic [1:0] h);
    @(negedge clk);
    rst = r; stall = st; flush = fl; in_valid = v; in_data = d;
    in_bubble = b; slot_flag_i = sl; hold_cnt_i = h;
    if (r) begin
      model = '0;
    end else if (fl) begin
      model.valid = 2'b00; model.data = 16'h0; model.bubble = 2'b11;
      model.slot = 1'b0; model.hold = 2'd0;
`ifdef PIPE_STAGE_STAT_EN
      if (model.sf != 16'hFFFF) model.sf = model.sf + 16'd1;
`endif
    end else if (st[STAGE] && !st[STAGE+1]) begin
      model.valid = 2'b00; model.data = 16'h0; model.bubble = 2'b11;
      model.hold = (h == 2'd3) ? 2'd3 : h + 2'd1;
`ifdef PIPE_STAGE_STAT_EN
      if (model.sb != 16'hFFFF) model.sb = model.sb + 16'd1;
`endif
    end else if (!st[STAGE]) begin
      model.valid = v; model.bubble = b; model.slot = sl; model.hold = 2'd0;
      model.data = {v[1] ? d[15:8] : 8'h00, v[0] ? d[7:0] : 8'h00};
    end
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    check_output(step);
  endtask

  initial begin
    model = '0;
    rst = 1'b1; stall = '0; flush = 1'b0; in_valid = '0; in_data = '0;
    in_bubble = '0; slot_flag_i = 1'b0; hold_cnt_i = '0;
    $display("[TB] start");
    apply_stimulus("reset",      1'b1, 6'b000111, 1'b1, 2'b11, 16'hFFFF, 2'b11, 1'b1, 2'd3);
    apply_stimulus("load",       1'b0, 6'b000000, 1'b0, 2'b11, 16'hA55A, 2'b00, 1'b1, 2'd2);
    apply_stimulus("lane_mask",  1'b0, 6'b000000, 1'b0, 2'b01, 16'hBEEF, 2'b10, 1'b1, 2'd1);
    apply_stimulus("hi_lane",    1'b0, 6'b100000, 1'b0, 2'b10, 16'hC3D4, 2'b01, 1'b1, 2'd0);
    apply_stimulus("bubble_h2",  1'b0, 6'b000111, 1'b0, 2'b11, 16'h5566, 2'b00, 1'b0, 2'd2);
    apply_stimulus("bubble_h3",  1'b0, 6'b000111, 1'b0, 2'b11, 16'h7788, 2'b00, 1'b0, 2'd3);
    apply_stimulus("bubble_h0",  1'b0, 6'b110100, 1'b0, 2'b11, 16'h99AA, 2'b00, 1'b0, 2'd0);
    apply_stimulus("load_1234",  1'b0, 6'b111011, 1'b0, 2'b11, 16'h1234, 2'b00, 1'b1, 2'd3);
    for (int i = 0; i < 3; i++)
      apply_stimulus("hold",     1'b0, 6'b001111, 1'b0, 2'b01, 16'hDEAD + 16'(i), 2'b11, 1'b0, 2'd1);
    apply_stimulus("flush_pri",  1'b0, 6'b000111, 1'b1, 2'b11, 16'hCAFE, 2'b00, 1'b1, 2'd2);
    apply_stimulus("flush_hold", 1'b0, 6'b001111, 1'b1, 2'b10, 16'h4242, 2'b01, 1'b1, 2'd1);
    apply_stimulus("reload",     1'b0, 6'b000000, 1'b0, 2'b11, 16'h0F0F, 2'b11, 1'b1, 2'd1);
    apply_stimulus("reset_mid",  1'b1, 6'b001111, 1'b0, 2'b11, 16'h1111, 2'b11, 1'b1, 2'd1);
    apply_stimulus("post_rst",   1'b0, 6'b000100, 1'b0, 2'b11, 16'h2222, 2'b00, 1'b1, 2'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
